// File: rtl/disp_scan_mux_n.sv
// Multi-source seven-segment scan driver: per-frame source selection with snapshot, time-multiplexed digits.
// Optional DISP_BLANK_ZERO_EN macro enables leading-zero suppression.
module disp_scan_mux_n #(
    parameter int N_SRC        = 2,
    parameter int DIGITS       = 4,
    parameter int SEL_W        = 1,
    parameter int REFRESH_DIV  = 50000,
    parameter int DWELL_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_SRC*DIGITS*4-1:0] src_data,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      auto_en,
    input  logic                      blank,
    output logic [6:0]                seg,
    output logic [DIGITS-1:0]         an,
    output logic [SEL_W-1:0]          cur_src,
    output logic                      frame_strobe
);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW_W  = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL_FRAMES - 1);
    localparam logic [SEL_W-1:0] SRC_LAST = SEL_W'(N_SRC - 1);

    logic [PRE_W-1:0]    prescaler;
    logic [DIG_W-1:0]    digit_idx;
    logic [DW_W-1:0]     dwell_cnt;
    logic [DIGITS*4-1:0] snapshot;
    logic                tick_d;

    logic                tick;
    logic                frame_wrap;
    logic [SEL_W-1:0]    next_src;
    logic [DW_W-1:0]     next_dwell;
    logic [DIGITS*4-1:0] next_snap;
    logic [3:0]          cur_nib;
    logic                lead_zero;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Source choice is evaluated every cycle but only committed on the frame wrap.
    always_comb begin
        tick       = (prescaler == PRE_LAST);
        frame_wrap = tick && (digit_idx == DIG_LAST);
        next_src   = cur_src;
        next_dwell = dwell_cnt;
        if (!auto_en) begin
            next_src   = (sel_in <= SRC_LAST) ? sel_in : '0;
            next_dwell = '0;
        end else if (dwell_cnt == DW_LAST) begin
            next_dwell = '0;
            next_src   = (cur_src == SRC_LAST) ? '0 : cur_src + 1'b1;
        end else begin
            next_dwell = dwell_cnt + 1'b1;
        end
        next_snap = src_data[int'(next_src)*DIGITS*4 +: DIGITS*4];
    end

    always_comb begin
        cur_nib = snapshot[int'(digit_idx)*4 +: 4];
`ifdef DISP_BLANK_ZERO_EN
        lead_zero = (digit_idx != '0);
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (d >= 32'(digit_idx) && snapshot[d*4 +: 4] != 4'h0) lead_zero = 1'b0;
        end
`else
        lead_zero = 1'b0;
`endif
        seg_next = lead_zero ? '0 : hex7(cur_nib);
        an_next  = DIGITS'(1) << digit_idx;
    end

    // Outputs update the cycle after the tick, using the already-advanced digit_idx and snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler    <= '0;
            digit_idx    <= DIG_LAST;
            dwell_cnt    <= '0;
            snapshot     <= '0;
            tick_d       <= 1'b0;
            seg          <= '0;
            an           <= '0;
            cur_src      <= '0;
            frame_strobe <= 1'b0;
        end else begin
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            tick_d       <= tick;
            frame_strobe <= frame_wrap;
            if (tick) digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
            if (frame_wrap) begin
                cur_src   <= next_src;
                dwell_cnt <= next_dwell;
                snapshot  <= next_snap;
            end
            if (tick_d) begin
                an  <= blank ? '0 : an_next;
                seg <= seg_next;
            end
        end
    end
endmodule

// File: tb/tb_disp_scan_mux_n.sv
// Directed scoreboard bench for disp_scan_mux_n (REFRESH_DIV=4, DIGITS=4, N_SRC=2, DWELL_FRAMES=2, SEL_W=2).
module tb_disp_scan_mux_n;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] src0, src1;
    logic [31:0] src_data;
    logic [1:0]  sel_in;
    logic        auto_en, blank;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  cur_src;
    logic        frame_strobe;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] src;
    } exp_t;
    exp_t q[$];

    logic [1:0] m_src;
    int         m_dwell;

    assign src_data = {src1, src0};

    disp_scan_mux_n #(
        .N_SRC(2), .DIGITS(4), .SEL_W(2), .REFRESH_DIV(4), .DWELL_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .src_data(src_data), .sel_in(sel_in),
        .auto_en(auto_en), .blank(blank), .seg(seg), .an(an),
        .cur_src(cur_src), .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_ref(input logic [3:0] n);
        logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[n];
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
`ifdef DISP_BLANK_ZERO_EN
        if (d > 0 && (v >> (d*4)) == 16'h0) return 7'h00;
`endif
        return hex_ref(v[d*4 +: 4]);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model the frame-boundary decision and queue the expected digit outputs of that frame.
    task automatic push_boundary(input int ndig);
        logic [15:0] val;
        exp_t e;
        if (!auto_en) begin
            m_src   = (sel_in < 2'd2) ? sel_in : 2'd0;
            m_dwell = 0;
        end else if (m_dwell == 1) begin
            m_dwell = 0;
            m_src   = (m_src == 2'd1) ? 2'd0 : 2'd1;
        end else begin
            m_dwell++;
        end
        val = (m_src == 2'd0) ? src0 : src1;
        for (int d = 0; d < ndig; d++) begin
            e.an  = blank ? 4'b0000 : (4'b0001 << d);
            e.seg = exp_seg(val, d);
            e.src = m_src;
            q.push_back(e);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            check("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            e = q.pop_front();
            check("an", 16'(an), 16'(e.an));
            check("seg", 16'(seg), 16'(e.seg));
            check("cur_src", 16'(cur_src), 16'(e.src));
        end
    endtask

    task automatic next_out();
        cyc(4);
        check_out();
    endtask

    task automatic run_frame(input int ndig);
        push_boundary(ndig);
        repeat (ndig) next_out();
    endtask

    task automatic check_reset_state();
        check("rst_seg", 16'(seg), 16'h0);
        check("rst_an", 16'(an), 16'h0);
        check("rst_cur_src", 16'(cur_src), 16'h0);
        check("rst_frame_strobe", 16'(frame_strobe), 16'h0);
    endtask

    // Release reset and follow the first frame; its boundary is the first tick.
    task automatic first_frame_after_reset();
        m_src   = 2'd0;
        m_dwell = 0;
        @(negedge clk) reset = 1'b0;
        cyc(3);
        check("fs_before_tick", 16'(frame_strobe), 16'h0);
        push_boundary(4);
        cyc(1);
        check("fs_first_tick", 16'(frame_strobe), 16'h1);
        cyc(1);
        check("fs_one_cycle", 16'(frame_strobe), 16'h0);
        check_out();
        repeat (3) next_out();
    endtask

    initial begin
        reset = 1'b1; src0 = 16'h1234; src1 = 16'h5678;
        sel_in = 2'd0; auto_en = 1'b0; blank = 1'b0;
        cyc(3);
        check_reset_state();
        first_frame_after_reset();

        // Tearing: data changed after the snapshot must not appear until the next frame.
        push_boundary(4);
        next_out();
        src0 = 16'hFFFF;
        repeat (3) next_out();
        run_frame(4);

        // Auto rotation every two frames.
        auto_en = 1'b1; src0 = 16'h1111; src1 = 16'h2222;
        repeat (4) run_frame(4);

        // Manual select; mid-frame select change waits for the next boundary.
        auto_en = 1'b0; sel_in = 2'd1;
        push_boundary(4);
        next_out();
        sel_in = 2'd3;
        repeat (3) next_out();
        run_frame(4);

        // Blank while scanning, then reset after digit 2.
        sel_in = 2'd1; blank = 1'b1;
        run_frame(3);
        @(negedge clk) reset = 1'b1;
        cyc(1);
        check_reset_state();
        blank = 1'b0; sel_in = 2'd0; src0 = 16'h0050;
        first_frame_after_reset();

        check("scoreboard_drained", 16'(q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
